// File: rtl/speed_test.sv
// speed_test: two gated ring oscillators, each clocking a 24-bit down-counter
// during a one-clk-period window; results are read a byte at a time through out.
module speed_test #(
    parameter int RING_STAGES = 25,
    parameter int COUNT_W     = 24,
    parameter int RING_DELAY  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [2:0] sel,
    input  logic [1:0] ring_en,
    output logic [7:0] out
);
    typedef enum logic [2:0] {IDLE = 3'd0, ARM, GATE, STOP, WAIT, DONE} state_t;
    state_t state;
    logic trig_q, fired, clear, gate;
    logic [1:0] ring_out;
    logic [1:0][COUNT_W-1:0] count;
    wire trig_ev = trig & ~trig_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            trig_q <= 1'b0;
            fired  <= 1'b0;
            clear  <= 1'b1;
            gate   <= 1'b0;
        end else begin
            trig_q <= trig;
            clear  <= 1'b0;
            gate   <= 1'b0;
            case (state)
                IDLE, DONE: if (trig_ev) begin
                    state <= ARM;
                    fired <= 1'b0;
                    clear <= 1'b1;
                end
                ARM: begin
                    state <= GATE;
                    gate  <= 1'b1;
                end
                GATE: state <= STOP;
                STOP: state <= WAIT;
                WAIT: begin
                    state <= DONE;
                    fired <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    for (genvar r = 0; r < 2; r++) begin : g_ring
        logic [RING_STAGES:0] n;
        logic [1:0] sync;
        logic [COUNT_W-1:0] cnt;
        // The feedback input is inverted so the loop stays oscillatory with an odd stage count
        assign #(RING_DELAY) n[0] = ~(ring_en[r] & ~n[RING_STAGES]);
        for (genvar s = 1; s <= RING_STAGES; s++) begin : g_inv
            assign #(RING_DELAY) n[s] = ~n[s-1];
        end
        always_ff @(posedge n[RING_STAGES] or posedge clear) begin
            if (clear) begin
                sync <= 2'b00;
                cnt  <= '1;
            end else begin
                sync <= {sync[0], gate};
                if (sync[1] && cnt != '0) cnt <= cnt - 1'b1;
            end
        end
        assign ring_out[r] = n[RING_STAGES];
        assign count[r]    = cnt;
    end
    always_comb begin
        case (sel)
            3'd0:    out = {1'b0, fired, ring_en, 1'b0, state};
            3'd1:    out = count[0][7:0];
            3'd2:    out = count[0][15:8];
            3'd3:    out = count[0][23:16];
            3'd4:    out = count[1][7:0];
            3'd5:    out = count[1][15:8];
            3'd6:    out = count[1][23:16];
            default: out = {1'b1, fired, ring_out[1], ring_out[0], 1'b0, state};
        endcase
    end
endmodule

// File: tb/tb_speed_test.sv
// tb_speed_test: directed checks of the speed monitor FSM, readout mux and ring counts.
module tb_speed_test;
    logic       clk, rst, trig;
    logic [2:0] sel;
    logic [1:0] ring_en;
    logic [7:0] out;
    int checks, errors;
    logic [23:0] c0, c1, d;
    logic [1:0] seen0, seen1;

    speed_test dut (
        .clk(clk), .rst(rst), .trig(trig), .sel(sel), .ring_en(ring_en), .out(out)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_count(input int idx, output logic [23:0] v);
        logic [2:0] keep;
        keep = sel;
        sel = 3'(1 + 3 * idx); #1 v[7:0]   = out;
        sel = sel + 3'd1;      #1 v[15:8]  = out;
        sel = sel + 3'd1;      #1 v[23:16] = out;
        sel = keep; #1;
    endtask

    // A 1000-unit window over a 52-unit ring period gives about 19 edges
    task automatic check_edges(input string tag, input logic [23:0] c);
        logic [23:0] e;
        e = 24'hFFFFFF - c;
        check(tag, (e >= 24'd17 && e <= 24'd21) ? 32'd19 : 32'(e), 32'd19);
    endtask

    task automatic measure();
        trig = 1'b1;
        tick(2);
        trig = 1'b0;
        tick(3);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; trig = 1'b0; sel = 3'd0; ring_en = 2'b00;
        tick(2);
        check("rst_status", 32'(out), 32'h00);
        sel = 3'd7; #1 check("rst_sel7", 32'(out), 32'h80);
        read_count(0, c0);
        check("rst_count0", 32'(c0), 32'hFFFFFF);

        rst = 1'b0; ring_en = 2'b11; sel = 3'd0;
        #1 check("idle_status", 32'(out), 32'h30);
        measure();
        check("done_status", 32'(out), 32'h75);
        ring_en = 2'b00; sel = 3'd7;
        #100 check("done_sel7", 32'(out), 32'hC5);
        read_count(0, c0);
        read_count(1, c1);
        check_edges("edges0", c0);
        check_edges("edges1", c1);
        d = (c0 > c1) ? c0 - c1 : c1 - c0;
        check("edge_diff", (d <= 24'd3) ? 32'd0 : 32'(d), 32'd0);
        check("no_overflow", {c0[23], c1[23]}, 2'b11);
        check("count_min", (c0 >= 24'd10 && c1 >= 24'd10) ? 32'd1 : 32'd0, 32'd1);

        sel = 3'd0; tick(1);
        measure();
        check("dis_status", 32'(out), 32'h45);
        read_count(0, c0);
        read_count(1, c1);
        check("dis_count0", 32'(c0), 32'hFFFFFF);
        check("dis_count1", 32'(c1), 32'hFFFFFF);

        ring_en = 2'b11; tick(1);
        trig = 1'b1; tick(1);
        trig = 1'b0; tick(1);
        check("mid_gate_state", 32'(out[2:0]), 32'd2);
        rst = 1'b1; tick(1);
        check("mid_rst_status", 32'(out), 32'h30);
        read_count(0, c0);
        read_count(1, c1);
        check("mid_rst_count0", 32'(c0), 32'hFFFFFF);
        check("mid_rst_count1", 32'(c1), 32'hFFFFFF);
        rst = 1'b0; tick(1);
        measure();
        check("retrig_status", 32'(out), 32'h75);
        read_count(0, c0);
        read_count(1, c1);
        check_edges("retrig_edges0", c0);
        check_edges("retrig_edges1", c1);

        rst = 1'b1; tick(1);
        rst = 1'b0; sel = 3'd7;
        seen0 = 2'b00; seen1 = 2'b00;
        for (int i = 0; i < 80; i++) begin
            #7;
            seen0 |= out[4] ? 2'b10 : 2'b01;
            seen1 |= out[5] ? 2'b10 : 2'b01;
        end
        check("status_bit7", 32'(out[7]), 32'd1);
        check("ring0_toggles", 32'(seen0), 32'd3);
        check("ring1_toggles", 32'(seen1), 32'd3);

        tick(1);
        trig = 1'b1; tick(1);
        trig = 1'b0; tick(1);
        trig = 1'b1; tick(1);
        check("ignored_trig_stop", 32'(out[2:0]), 32'd3);
        tick(1);
        check("ignored_trig_wait", 32'(out[2:0]), 32'd4);
        tick(1);
        check("ignored_trig_done", 32'(out[6:0]), 32'h45 | (32'(out[5:4]) << 4));
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("held_trig_state", 32'(out[2:0]), 32'd5);
        end
        check("held_trig_fired", 32'(out[6]), 32'd1);
        trig = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/speed_test.md
Name: speed_test

Overview:
- On-chip speed monitor: two gated ring oscillators, each driving a 24-bit down-counter.
- A trigger opens a measurement window exactly one clk period long. Each counter records the ring edges that occur inside that window.
- Results and status are read byte-by-byte through an 8-bit output selected by a 3-bit select.
- Sits behind the 8-in/8-out pin wrapper; the wrapper maps pins to these ports and inverts the pin-level reset.

Parameters:
- RING_STAGES, 25: inverter stages per ring, not counting the enable gate; must be odd.
- COUNT_W, 24: counter width; readout logic is fixed at 3 bytes per counter.
- RING_DELAY, 1: per-stage delay in simulation time units (simulation only; ignored by synthesis).

Ports:
- clk  input  1  system clock; the measurement window is one period of clk.
- rst  input  1  synchronous reset, active-high.
- trig  input  1  measurement trigger; a rising edge, sampled on clk, starts a measurement.
- sel  input  3  output select.
- ring_en  input  2  bit0 enables ring 0, bit1 enables ring 1; when 0 the ring is held static.
- out  output  8  selected data or status.

Behaviour:
- Rings: each is an enable-NAND followed by RING_STAGES inverters in a loop. Ring n oscillates only while ring_en[n]=1. Keep them as separate loops, one per counter, never shared.
- trig_q: a clk register holding the previous trig. Trigger event = trig & ~trig_q.
- FSM (clk domain, 3 bits) codes:
  - IDLE=0, ARM=1, GATE=2, STOP=3, WAIT=4, DONE=5.
  - IDLE/DONE -> ARM on trigger event.
  - ARM -> GATE -> STOP -> WAIT -> DONE, one state per clk posedge, unconditionally.
  - A trigger event outside IDLE/DONE is ignored.
- clear: asserted while in ARM. It asynchronously presets both counters to 24'hFFFFFF; this is the only async path.
- gate: high only while in GATE, i.e. exactly one clk period. It is synchronized into each ring domain with a 2-flop synchronizer clocked by that ring's output.
- Counters: decrement by 1 on each ring rising edge while the synchronized gate is 1. They saturate at 0 and never wrap.
- Counter read in clk domain: valid only when the state is DONE. Counters are frozen then because gate is low and has propagated through the synchronizers.
- fired flag: set on entry to DONE. Cleared by rst and on a new trigger event.
- Measured frequency = (24'hFFFFFF - count) edges per clk period.
  - count[23]=0 means more than 2^23 edges: treat as an overflow indication.
  - With ring_en=0 the counts stay 24'hFFFFFF.
- out mux (combinational from registered state/counters):
  - 000: {0, fired, ring_en[1:0], 1'b0, state[2:0]}.
  - 001/010/011: count0 [7:0]/[15:8]/[23:16].
  - 100/101/110: count1 [7:0]/[15:8]/[23:16].
  - 111 (status/debug): {1, fired, ring1_out, ring0_out, 1'b0, state[2:0]}.
- out[7] is 1 only for sel=111 or for count bytes whose bit 7 is set. It follows sel combinationally, including while rst=1.
- rst=1 on a clk posedge:
  - state=IDLE, fired=0, trig_q=0.
  - Forces clear for that cycle, so counters return to 24'hFFFFFF, aborting any measurement in progress.
- No clk-domain reset is needed for ring-domain synchronizers beyond clear. clear also resets them to 0.

Test Plan:
1. Smoke: rst=1, sel=000 -> out[7]=0, out[6]=0. Set sel=111 -> out[7]=1 before the next clk posedge.
2. Measurement: rst=0, ring_en=11, sel=000 (out[7]=0, out[6]=0). Raise trig for 2 clk cycles, wait 3 more posedges; set ring_en=00, sel=111 -> out[6]=1.
3. Measurement readout: read bytes with sel 001..110.
   - count0 ≥10 and count1 ≥10.
   - |count0-count1| ≤ 3.
   - count0[23]=1 and count1[23]=1.
   - (FFFFFF-count) matches period/(2·RING_STAGES+2)·RING_DELAY within ±2.
4. Disabled rings: ring_en=00, trigger a measurement -> fired=1, both counts read 24'hFFFFFF.
5. Reset mid-measurement: trigger, then assert rst during GATE -> state=IDLE, fired=0, counts 24'hFFFFFF. A re-trigger after release completes normally.
6. Status: after one rst cycle, sel=111 with ring_en=11 -> out[7]=1 and out[5:4] toggling. A trig held high without a fresh rising edge never starts a new measurement.
